// File: rtl/trig_pkg.sv
// Shared definitions for the quarter-wave sine/cosine pipeline:
// geometry helpers, quadrant encoding and the ROM content generator.
package trig_pkg;

  typedef enum logic [1:0] {Q0 = 2'd0, Q1 = 2'd1, Q2 = 2'd2, Q3 = 2'd3} quadrant_t;

  // pi/2 in Q30 fixed point
  localparam longint HALF_PI_Q30 = 64'sd1686629713;

  function automatic int quarter_size(input int phase_w);
    return 1 << (phase_w - 2);
  endfunction

  function automatic int amplitude(input int out_w);
    return (1 << (out_w - 1)) - 1;
  endfunction

  // round(amp * sin(pi/2 * k / n)) via a Q30 Taylor series; elaboration-time only
  function automatic int quarter_sin(input int k, input int n, input int amp);
    longint x, term, acc, v;
    x    = (HALF_PI_Q30 * longint'(k)) / longint'(n);
    term = x;
    acc  = x;
    for (int t = 1; t <= 8; t++) begin
      term = (term * x) >>> 30;
      term = (term * x) >>> 30;
      term = term / longint'((2 * t) * (2 * t + 1));
      if (t % 2 == 1) acc = acc - term;
      else            acc = acc + term;
    end
    v = (acc * longint'(amp) + (longint'(1) <<< 29)) >>> 30;
    if (v > longint'(amp)) v = longint'(amp);
    if (v < 0) v = 0;
    return int'(v);
  endfunction

endpackage

// File: rtl/quarter_sin_rom.sv
// Quarter-wave sine table, one registered read per enabled cycle.
// Addresses above the quarter point alias the peak amplitude.
module quarter_sin_rom
  import trig_pkg::*;
#(
  parameter int ADDR_W = 11,
  parameter int DATA_W = 9
) (
  input  logic              clk,
  input  logic              en,
  input  logic [ADDR_W-1:0] addr,
  output logic [DATA_W-1:0] data
);

  localparam int N     = quarter_size(ADDR_W + 1);
  localparam int A     = amplitude(DATA_W + 1);
  localparam int DEPTH = 1 << ADDR_W;

  logic [DATA_W-1:0] tbl [DEPTH];

  for (genvar g = 0; g < DEPTH; g++) begin : g_entry
    localparam int ENTRY = quarter_sin((g > N) ? N : g, N, A);
    assign tbl[g] = DATA_W'(ENTRY);
  end

  always_ff @(posedge clk) begin
    if (en) data <= tbl[addr];
  end

endmodule

// File: rtl/trig_lut_pipe.sv
// Three-stage sine/cosine evaluator (fold, ROM, sign) with pass-through tag.
// Single global enable: the whole pipe stalls while the output is held.
module trig_lut_pipe
  import trig_pkg::*;
#(
  parameter int PHASE_W = 12,
  parameter int OUT_W   = 10,
  parameter int TAG_W   = 2
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [PHASE_W-1:0] in_phase,
  input  logic               in_iscos,
  input  logic [TAG_W-1:0]   in_tag,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [OUT_W-1:0]   out_value,
  output logic [TAG_W-1:0]   out_tag
);

  localparam int N = quarter_size(PHASE_W);
  localparam logic [PHASE_W-1:0] COS_OFF = PHASE_W'(N);
  localparam logic [PHASE_W-2:0] K_MAX   = (PHASE_W - 1)'(N);

  logic en;
  assign en       = out_ready | ~out_valid;
  assign in_ready = en;

  // Stage 1: fold the phase into a quarter-wave index
  logic [PHASE_W-1:0] p;
  quadrant_t          q;
  logic [PHASE_W-3:0] i;
  logic [PHASE_W-2:0] k;

  always_comb begin
    p = in_phase + (in_iscos ? COS_OFF : '0);
    q = quadrant_t'(p[PHASE_W-1 -: 2]);
    i = p[PHASE_W-3:0];
    k = {1'b0, i};
    if (q == Q1 || q == Q3) k = K_MAX - {1'b0, i};
  end

  logic               s1_vld, s2_vld;
  logic [PHASE_W-2:0] s1_k;
  logic               s1_neg, s2_neg;
  logic [TAG_W-1:0]   s1_tag, s2_tag;
  logic [OUT_W-2:0]   rom_data;

  quarter_sin_rom #(
    .ADDR_W (PHASE_W - 1),
    .DATA_W (OUT_W - 1)
  ) u_rom (
    .clk  (clk),
    .en   (en),
    .addr (s1_k),
    .data (rom_data)
  );

  // Stage 3: apply sign; a negated zero naturally stays zero
  logic [OUT_W-1:0] mag;
  assign mag = {1'b0, rom_data};

  always_ff @(posedge clk) begin
    if (rst) begin
      s1_vld    <= 1'b0;
      s2_vld    <= 1'b0;
      out_valid <= 1'b0;
      out_value <= '0;
      out_tag   <= '0;
    end else if (en) begin
      s1_vld    <= in_valid;
      s2_vld    <= s1_vld;
      out_valid <= s2_vld;
      out_value <= s2_neg ? (OUT_W'(0) - mag) : mag;
      out_tag   <= s2_tag;
    end
  end

  always_ff @(posedge clk) begin
    if (en) begin
      s1_k   <= k;
      s1_neg <= p[PHASE_W-1];
      s1_tag <= in_tag;
      s2_neg <= s1_neg;
      s2_tag <= s1_tag;
    end
  end

endmodule

// File: tb/tb_trig_lut_pipe.sv
// Directed bench with an expected-result queue for trig_lut_pipe,
// plus a second instance at PHASE_W=8, OUT_W=16.
module tb_trig_lut_pipe;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst;
  logic        in_valid, in_ready, in_iscos, out_valid, out_ready;
  logic [11:0] in_phase;
  logic [1:0]  in_tag, out_tag;
  logic [9:0]  out_value;

  logic        in_valid8, in_ready8, in_iscos8, out_valid8, out_ready8;
  logic [7:0]  in_phase8;
  logic [1:0]  in_tag8, out_tag8;
  logic [15:0] out_value8;

  trig_lut_pipe u_dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .in_phase(in_phase), .in_iscos(in_iscos), .in_tag(in_tag),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_value(out_value), .out_tag(out_tag)
  );

  trig_lut_pipe #(.PHASE_W(8), .OUT_W(16), .TAG_W(2)) u_dut8 (
    .clk(clk), .rst(rst), .in_valid(in_valid8), .in_ready(in_ready8),
    .in_phase(in_phase8), .in_iscos(in_iscos8), .in_tag(in_tag8),
    .out_valid(out_valid8), .out_ready(out_ready8),
    .out_value(out_value8), .out_tag(out_tag8)
  );

  typedef struct {
    int val;
    int tag;
    int tol;
    int acc;
    bit lat;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   failures = 0;
  int   cyc = 0;
  bit   tog = 1'b0;
  int   tog_idx = 0;
  bit   tog_pat [4] = '{1'b1, 1'b0, 1'b0, 1'b1};

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input int got, input int exp);
    checks++;
    assert (got === exp) else begin
      failures++;
      $error("FAIL %s got=%0d exp=%0d", name, got, exp);
    end
  endtask

  task automatic chk_tol(input string name, input int got, input int exp, input int tol);
    checks++;
    assert (got >= exp - tol && got <= exp + tol) else begin
      failures++;
      $error("FAIL %s got=%0d exp=%0d tol=%0d", name, got, exp, tol);
    end
  endtask

  function automatic int ref_sin(input int pp);
    real r;
    r = 511.0 * $sin(2.0 * 3.14159265358979 * pp / 4096.0);
    if (r >= 0.0) return $rtoi(r + 0.5);
    return -$rtoi(-r + 0.5);
  endfunction

  task automatic step_ready();
    if (tog) begin
      out_ready = tog_pat[tog_idx % 4];
      tog_idx++;
    end
  endtask

  // Offer one sample; it is accepted at the first edge with in_ready high.
  task automatic send(input int phase, input bit iscos, input int tag,
                      input int expv, input int tol, input bit lat);
    int   guard;
    exp_t e;
    guard    = 0;
    in_valid = 1'b1;
    in_phase = 12'(phase);
    in_iscos = iscos;
    in_tag   = 2'(tag);
    forever begin
      @(negedge clk);
      if (in_ready === 1'b1) break;
      guard++;
      if (guard > 100) begin
        chk("send_timeout", guard, 0);
        break;
      end
      @(posedge clk); #1;
      step_ready();
    end
    e.val = expv; e.tag = tag; e.tol = tol; e.acc = cyc + 1; e.lat = lat;
    sb.push_back(e);
    @(posedge clk); #1;
    step_ready();
    in_valid = 1'b0;
  endtask

  task automatic drain();
    int g;
    g = 0;
    in_valid = 1'b0;
    while (sb.size() > 0 && g < 200) begin
      @(posedge clk); #1;
      step_ready();
      g++;
    end
    chk("drain_empty", sb.size(), 0);
    repeat (2) begin
      @(posedge clk); #1;
      step_ready();
    end
  endtask

  // Output monitor: pops on every transfer, checks held data against the queue head
  exp_t mon_e;
  int   mon_got;
  always @(negedge clk) begin
    if (rst === 1'b0) begin
      chk("in_ready", int'(in_ready), int'(!(out_valid === 1'b1 && out_ready === 1'b0)));
      mon_got = int'($signed(out_value));
      if (out_valid === 1'b1 && out_ready === 1'b1) begin
        if (sb.size() == 0) begin
          chk("spurious_output", mon_got, -9999);
        end else begin
          mon_e = sb.pop_front();
          chk_tol("out_value", mon_got, mon_e.val, mon_e.tol);
          chk("out_tag", int'(out_tag), mon_e.tag);
          if (mon_e.lat) chk("latency", cyc - mon_e.acc, 2);
        end
      end else if (out_valid === 1'b1 && out_ready === 1'b0 && sb.size() > 0) begin
        chk_tol("held_value", mon_got, sb[0].val, sb[0].tol);
        chk("held_tag", int'(out_tag), sb[0].tag);
      end
    end
  end

  int t1_ph  [6] = '{0, 512, 1024, 2048, 3072, 4095};
  int t1_exp [6] = '{0, 361, 511, 0, -511, -1};
  int t2_ph  [3] = '{0, 1024, 3072};
  int t2_exp [3] = '{511, 0, 0};

  initial begin
    int pp, ph;
    rst = 1'b1; in_valid = 1'b0; in_phase = '0; in_iscos = 1'b0; in_tag = '0; out_ready = 1'b1;
    in_valid8 = 1'b0; in_phase8 = '0; in_iscos8 = 1'b0; in_tag8 = '0; out_ready8 = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_out_valid", int'(out_valid), 0);
    chk("rst_out_value", int'(out_value), 0);
    chk("rst_out_tag", int'(out_tag), 0);
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    chk("in_ready_after_rst", int'(in_ready), 1);
    @(posedge clk); #1;

    // Sine spot values, back to back
    for (int j = 0; j < 6; j++) send(t1_ph[j], 1'b0, j % 4, t1_exp[j], 0, 1'b1);
    drain();

    // Cosine spot values, including wrap of the offset
    for (int j = 0; j < 3; j++) send(t2_ph[j], 1'b1, j % 4, t2_exp[j], 0, 1'b1);
    drain();

    // Stream under toggling out_ready
    tog = 1'b1; tog_idx = 0;
    for (int j = 0; j < 16; j++) begin
      ph = int'($urandom_range(0, 4095));
      send(ph, 1'b0, j % 4, ref_sin(ph), 1, 1'b0);
    end
    drain();
    tog = 1'b0; out_ready = 1'b1;

    // Reset with three samples in flight (none are expected back)
    out_ready = 1'b0;
    in_valid  = 1'b1;
    for (int j = 0; j < 3; j++) begin
      in_phase = 12'(100 * (j + 1));
      in_tag   = 2'(j);
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    rst      = 1'b1;
    @(posedge clk); #1;
    rst       = 1'b0;
    out_ready = 1'b1;
    @(negedge clk);
    chk("post_rst_out_valid", int'(out_valid), 0);
    repeat (4) @(posedge clk);
    #1;
    send(1024, 1'b0, 2, 511, 0, 1'b1);
    drain();

    // Full sweep, sine then cosine
    for (int c = 0; c < 2; c++) begin
      for (int p = 0; p < 4096; p++) begin
        pp = (p + c * 1024) % 4096;
        send(p, c[0], p % 4, ref_sin(pp), (pp % 1024 == 0) ? 0 : 1, 1'b1);
      end
    end
    drain();

    // Wider output, narrower phase
    in_valid8 = 1'b1; in_phase8 = 8'd64; in_tag8 = 2'd1;
    @(posedge clk); #1;
    in_phase8 = 8'd192; in_tag8 = 2'd2;
    @(posedge clk); #1;
    in_valid8 = 1'b0;
    @(negedge clk);
    chk("w16_early_valid", int'(out_valid8), 0);
    @(negedge clk);
    chk("w16_valid_a", int'(out_valid8), 1);
    chk("w16_value_a", int'($signed(out_value8)), 32767);
    chk("w16_tag_a", int'(out_tag8), 1);
    @(negedge clk);
    chk("w16_valid_b", int'(out_valid8), 1);
    chk("w16_value_b", int'($signed(out_value8)), -32767);
    chk("w16_tag_b", int'(out_tag8), 2);

    chk("final_queue_empty", sb.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
